// File: rtl/sha_pkg.sv
// Shared constants and FSM encoding for the single-block SHA-256 unpadder.
package sha_pkg;

  localparam int BLOCK_W       = 512;
  localparam int LEN_W         = 64;
  localparam int MAX_MSG_BYTES = 55;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    STREAM,
    FINISH
  } state_e;

endpackage

// File: rtl/sha_pad_check.sv
// Combinational validation of a padded SHA-256 block: 0x80 terminator right after
// the message, zero fill up to byte 55, and a whole-byte length of at most 55 bytes.
module sha_pad_check
  import sha_pkg::*;
(
  input  logic [BLOCK_W-1:0] block,
  output logic               valid,
  output logic [5:0]         len_bytes
);

  logic [LEN_W-1:0] lenField;

  assign lenField  = block[LEN_W-1:0];
  assign len_bytes = lenField[8:3];

  // Length checks also guarantee len_bytes <= 55, so the byte scan below covers the terminator.
  always_comb begin
    valid = (lenField[2:0] == 3'b000) && (lenField <= 64'd440) && (lenField[63:9] == 55'd0);
    for (int i = 0; i <= MAX_MSG_BYTES; i++) begin
      if (i == int'(len_bytes)) begin
        if (block[BLOCK_W-1-8*i -: 8] != 8'h80) valid = 1'b0;
      end else if (i > int'(len_bytes)) begin
        if (block[BLOCK_W-1-8*i -: 8] != 8'h00) valid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sha_unpadder.sv
// Accepts one padded SHA-256 block, validates its padding and streams the message
// bytes out with valid/ready, finishing with a one-cycle done/err/msg_len report.
module sha_unpadder
  import sha_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_block,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_byte,
  output logic               out_last,
  output logic               done,
  output logic               err,
  output logic [5:0]         msg_len
);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic [5:0]         byteIdx_q, byteIdx_d;
  logic               err_q, err_d;
  logic [5:0]         msgLen_q, msgLen_d;

  logic               padValid;
  logic [5:0]         lenBytes;
  logic [7:0]         curByte;

  sha_pad_check uPadCheck (
    .block     (block_q),
    .valid     (padValid),
    .len_bytes (lenBytes)
  );

  always_comb begin
    curByte = 8'h00;
    for (int i = 0; i < MAX_MSG_BYTES; i++) begin
      if (byteIdx_q == 6'(i)) curByte = block_q[BLOCK_W-1-8*i -: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      block_q   <= '0;
      byteIdx_q <= '0;
      err_q     <= 1'b0;
      msgLen_q  <= '0;
    end else begin
      state_q   <= state_d;
      block_q   <= block_d;
      byteIdx_q <= byteIdx_d;
      err_q     <= err_d;
      msgLen_q  <= msgLen_d;
    end
  end

  // Status registers are loaded on the transition into FINISH so they are valid alongside done.
  always_comb begin
    state_d   = state_q;
    block_d   = block_q;
    byteIdx_d = byteIdx_q;
    err_d     = err_q;
    msgLen_d  = msgLen_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          block_d = in_block;
          state_d = CHECK;
        end
      end
      CHECK: begin
        byteIdx_d = '0;
        if (padValid && (lenBytes != 6'd0)) begin
          state_d = STREAM;
        end else begin
          state_d  = FINISH;
          err_d    = !padValid;
          msgLen_d = padValid ? lenBytes : 6'd0;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        out_byte  = curByte;
        out_last  = (byteIdx_q == lenBytes - 6'd1);
        if (out_ready) begin
          if (out_last) begin
            state_d  = FINISH;
            err_d    = 1'b0;
            msgLen_d = lenBytes;
          end else begin
            byteIdx_d = byteIdx_q + 6'd1;
          end
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err     = err_q;
  assign msg_len = msgLen_q;

endmodule

// File: tb/tb_sha_unpadder.sv
// Randomized self-checking bench for sha_unpadder: a byte-level model of the
// padding rules feeds a per-cycle compare process, plus directed corner blocks.
module tb_sha_unpadder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_block;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_byte;
  logic         out_last;
  logic         done;
  logic         err;
  logic [5:0]   msg_len;

  sha_unpadder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .done      (done),
    .err       (err),
    .msg_len   (msg_len)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int compared   = 0;
  int mismatched = 0;

  byte unsigned expQ[$];
  bit           active = 1'b0;
  bit           expErr;
  int           expLen;
  bit           holdErr = 1'b0;
  int           holdLen = 0;
  bit           doneSeen;
  int           doneCycle, firstValidCycle, lastHsCycle, hsCount, acceptCycle;
  bit           prevStall = 1'b0;
  logic [7:0]   prevByte;
  logic         prevLast;

  task automatic checkOutput(input string name, input longint actual, input longint required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, required, $time);
    end
  endtask

  // Reference model: decode straight from the byte view of the block.
  function automatic void modelDecode(input logic [511:0] blk, output bit ok, output int len);
    byte unsigned     b[64];
    longint unsigned  lenBits;
    for (int i = 0; i < 64; i++) b[i] = blk[511-8*i -: 8];
    lenBits = blk[63:0];
    ok  = (lenBits % 8 == 0) && (lenBits <= 440);
    len = ok ? int'(lenBits / 8) : 0;
    if (ok) begin
      if (b[len] != 8'h80) ok = 1'b0;
      for (int j = len + 1; j < 56; j++) if (b[j] != 8'h00) ok = 1'b0;
    end
    if (!ok) len = 0;
  endfunction

  function automatic logic [511:0] buildBlock(input int len, input bit counting);
    logic [511:0] blk;
    blk = '0;
    for (int i = 0; i < len; i++) blk[511-8*i -: 8] = counting ? 8'(i) : 8'($urandom);
    blk[511-8*len -: 8] = 8'h80;
    blk[63:0] = 64'(len * 8);
    return blk;
  endfunction

  task automatic compareCycle();
    if (out_valid) begin
      if (firstValidCycle < 0) firstValidCycle = cycle;
      if (expQ.size() == 0) begin
        checkOutput("unexpected out_valid", 1, 0);
      end else begin
        checkOutput("out_byte", out_byte, expQ[0]);
        checkOutput("out_last", out_last, expQ.size() == 1);
      end
      if (prevStall) begin
        checkOutput("stalled out_byte stable", out_byte, prevByte);
        checkOutput("stalled out_last stable", out_last, prevLast);
      end
      prevStall = !out_ready;
      prevByte  = out_byte;
      prevLast  = out_last;
      if (out_ready) begin
        if (expQ.size() > 0) void'(expQ.pop_front());
        hsCount++;
        lastHsCycle = cycle;
      end
    end else begin
      if (prevStall) checkOutput("out_valid dropped while stalled", 0, 1);
      prevStall = 1'b0;
      checkOutput("out_last without out_valid", out_last, 0);
    end
    if (active) checkOutput("in_ready while busy", in_ready, 0);
    if (done) begin
      if (!active) begin
        checkOutput("unexpected done", 1, 0);
      end else begin
        checkOutput("err at done", err, expErr);
        checkOutput("msg_len at done", msg_len, expLen);
        checkOutput("bytes left at done", expQ.size(), 0);
        holdErr = expErr;
        holdLen = expLen;
      end
      doneSeen  = 1'b1;
      doneCycle = cycle;
      active    = 1'b0;
    end else begin
      checkOutput("err hold", err, holdErr);
      checkOutput("msg_len hold", msg_len, holdLen);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) compareCycle();
    end
  end

  // mode 0: out_ready high, 1: three stall cycles before each byte, 2: random out_ready.
  task automatic applyStimulus(input logic [511:0] blk, input int mode, input bit pin,
                               input bit pinOk, input int pinLen, input int resetAfter);
    bit ok;
    int len;
    int waitCnt;
    int n;
    modelDecode(blk, ok, len);
    if (pin) begin
      checkOutput("model ok", ok, pinOk);
      checkOutput("model length", len, pinLen);
    end
    expQ.delete();
    for (int i = 0; i < len; i++) expQ.push_back(blk[511-8*i -: 8]);
    expErr          = !ok;
    expLen          = len;
    doneSeen        = 1'b0;
    firstValidCycle = -1;
    hsCount         = 0;

    @(negedge clk);
    in_valid  = 1'b1;
    in_block  = blk;
    out_ready = (mode == 0);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("in_ready timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    acceptCycle = cycle;
    @(negedge clk);
    in_valid = 1'b0;
    in_block = {16{$urandom}};
    active   = 1'b1;

    waitCnt = 0;
    n = 0;
    while (!doneSeen && n < 600) begin
      if (resetAfter >= 0 && hsCount >= resetAfter) begin
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_byte", out_byte, 0);
        checkOutput("reset out_last", out_last, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset msg_len", msg_len, 0);
        checkOutput("reset in_ready", in_ready, 0);
        active    = 1'b0;
        expQ.delete();
        prevStall = 1'b0;
        holdErr   = 1'b0;
        holdLen   = 0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        return;
      end
      if (mode == 1) begin
        if (out_valid) begin
          if (waitCnt == 3) begin
            out_ready = 1'b1;
            waitCnt   = 0;
          end else begin
            out_ready = 1'b0;
            waitCnt++;
          end
        end else begin
          out_ready = 1'b0;
        end
      end else if (mode == 2) begin
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n++;
    end

    if (!doneSeen) begin
      checkOutput("done timeout", 0, 1);
      active = 1'b0;
    end else if (ok && len > 0) begin
      checkOutput("first out_valid latency", firstValidCycle - acceptCycle, 2);
      checkOutput("done after last handshake", doneCycle - lastHsCycle, 1);
      if (mode == 0) checkOutput("done latency", doneCycle - acceptCycle, 2 + len);
    end else begin
      checkOutput("first out_valid absent", firstValidCycle, -1);
      checkOutput("done latency", doneCycle - acceptCycle, 2);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [511:0] abc;
    logic [511:0] blk;
    int           len;
    int           kind;
    int           pos;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_block  = '0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_byte", out_byte, 0);
    checkOutput("reset out_last", out_last, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset msg_len", msg_len, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("in_ready after release", in_ready, 1);

    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[63:0]    = 64'h18;

    applyStimulus(abc, 0, 1'b1, 1'b1, 3, -1);
    applyStimulus(abc, 1, 1'b1, 1'b1, 3, -1);

    blk = '0;
    blk[511:504] = 8'h80;
    applyStimulus(blk, 0, 1'b1, 1'b1, 0, -1);

    blk = abc;
    blk[511-24 -: 8] = 8'h81;
    applyStimulus(blk, 0, 1'b1, 1'b0, 0, -1);
    blk = abc;
    blk[63:0] = 64'h17;
    applyStimulus(blk, 0, 1'b1, 1'b0, 0, -1);
    blk = abc;
    blk[63:0] = 64'h1C0;
    applyStimulus(blk, 0, 1'b1, 1'b0, 0, -1);

    blk = buildBlock(55, 1'b1);
    applyStimulus(blk, 0, 1'b1, 1'b1, 55, -1);
    applyStimulus(blk, 2, 1'b0, 1'b0, 0, -1);

    applyStimulus(abc, 0, 1'b0, 1'b0, 0, 2);
    applyStimulus(abc, 0, 1'b1, 1'b1, 3, -1);

    for (int t = 0; t < 60; t++) begin
      len  = int'($urandom_range(0, 55));
      blk  = buildBlock(len, 1'b0);
      kind = int'($urandom_range(0, 5));
      if (kind == 3) begin
        pos = int'($urandom_range(55, len));
        blk[511-8*pos -: 8] = blk[511-8*pos -: 8] ^ 8'($urandom_range(1, 255));
      end else if (kind == 4) begin
        blk[63:0] = blk[63:0] + 64'($urandom_range(1, 7));
      end else if (kind == 5) begin
        blk[63:0] = {$urandom, $urandom};
      end
      applyStimulus(blk, int'($urandom_range(0, 2)), 1'b0, 1'b0, 0, -1);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
